// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell and one carry flop.
// It processes one bit per clock over WIDTH cycles and uses a start/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_ws;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_c;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic             w_load;

    // The exit edge of DONE also accepts start, giving a WIDTH+1 cycle issue interval.
    always_comb begin
        w_s    = r_ra[0] ^ r_rb[0] ^ r_c;
        w_c    = (r_ra[0] & r_rb[0]) | (r_ra[0] & r_c) | (r_rb[0] & r_c);
        w_last = (r_cnt == CW'(WIDTH - 1));
        w_load = start && ((r_state == IDLE) || (r_state == DONE));
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == RUN);
            r_done  <= (w_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra   <= '0;
            r_rb   <= '0;
            r_ws   <= '0;
            r_cnt  <= '0;
            r_c    <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_load) begin
            r_ra  <= A;
            r_rb  <= B;
            r_ws  <= '0;
            r_cnt <= '0;
            r_c   <= 1'b0;
        end else if (r_state == RUN) begin
            r_ra  <= {1'b0, r_ra[WIDTH-1:1]};
            r_rb  <= {1'b0, r_rb[WIDTH-1:1]};
            r_ws  <= {w_s, r_ws[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
            r_c   <= w_c;
            if (w_last) begin
                r_sum  <= {w_s, r_ws[WIDTH-1:1]};
                r_cout <= w_c;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Sum  = r_sum;
    assign Cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for vectors and handshake
// cases, and a 4-bit instance for the exhaustive back-to-back sweep.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int testsRun = 0;
    int failCount = 0;
    int cycleCount = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
        string      name;
    } vec_t;

    vec_t vecs[6];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one 8-bit add, scramble operands after acceptance, then verify timing and result.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] expSum, input logic expCout,
                                 input string name);
        int         lat;
        logic       seen;
        logic       busyOk;
        logic       holdOk;
        logic [7:0] prevSum;
        logic       prevCout;
        @(negedge clk);
        start8   = 1'b1;
        a8       = a;
        b8       = b;
        prevSum  = sum8;
        prevCout = cout8;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8     = ~a;
        b8     = b ^ 8'h5A;
        seen   = 1'b0;
        lat    = -1;
        busyOk = 1'b1;
        holdOk = 1'b1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (done8) begin
                seen = 1'b1;
                lat  = k - 1;
            end else begin
                if (busy8 !== 1'b1) busyOk = 1'b0;
                if (sum8 !== prevSum || cout8 !== prevCout) holdOk = 1'b0;
            end
        end
        checkOutput({name, "_latency"}, lat, 32'd8);
        checkOutput({name, "_busy_run"}, 32'(busyOk), 32'd1);
        checkOutput({name, "_no_partial"}, 32'(holdOk), 32'd1);
        checkOutput({name, "_sum"}, 32'(sum8), 32'(expSum));
        checkOutput({name, "_cout"}, 32'(cout8), 32'(expCout));
        checkOutput({name, "_busy_at_done"}, 32'(busy8), 32'd0);
        @(negedge clk);
        checkOutput({name, "_done_pulse"}, 32'(done8), 32'd0);
        checkOutput({name, "_sum_hold"}, 32'({cout8, sum8}), 32'({expCout, expSum}));
    endtask

    initial begin
        int         e0;
        int         doneSeen;
        logic       seen;
        logic [4:0] exp4;
        logic [7:0] idx;
        logic       overlap;

        vecs[0] = '{8'h3C, 8'h15, 8'h51, 1'b0, "basic"};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, "wrap"};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, "max"};
        vecs[3] = '{8'hA5, 8'h5A, 8'hFF, 1'b0, "alt"};
        vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1, "msb"};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0, "zero"};

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_async", 32'({busy8, done8, cout8, sum8}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_quiet", 32'({busy8, done8, cout8, sum8}), 32'd0);
        end

        foreach (vecs[i]) applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout, vecs[i].name);

        // Start held high: operands change mid-run; the second op must be accepted at E9
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h10;
        b8     = 8'h20;
        @(posedge clk);
        #1;
        e0 = cycleCount;
        repeat (2) @(posedge clk);
        #1;
        a8 = 8'h77;
        b8 = 8'h77;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = done8;
        end
        checkOutput("held_done1_edge", 32'(cycleCount - e0), 32'd8);
        checkOutput("held_result1", 32'({cout8, sum8}), 32'h030);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        @(negedge clk);
        checkOutput("held_accept_e9", 32'({busy8, done8}), 32'b10);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = done8;
        end
        checkOutput("held_done2_edge", 32'(cycleCount - e0), 32'd17);
        checkOutput("held_result2", 32'({cout8, sum8}), 32'h0EE);

        // Reset mid-operation discards the add and clears outputs without waiting for a clock
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h80;
        b8     = 8'h80;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_clear", 32'({busy8, done8, cout8, sum8}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1'b1;
        end
        checkOutput("midreset_no_done", 32'(seen), 32'd0);
        applyStimulus(8'h01, 8'h02, 8'h03, 1'b0, "after_reset");

        // Exhaustive 4-bit sweep issued back-to-back at the minimum interval
        doneSeen = 0;
        overlap  = 1'b0;
        @(negedge clk);
        start4 = 1'b1;
        a4     = 4'h0;
        b4     = 4'h0;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    @(posedge clk);
                    #1;
                    if (i < 255) begin
                        idx = 8'(i + 1);
                        a4  = idx[7:4];
                        b4  = idx[3:0];
                    end else begin
                        start4 = 1'b0;
                    end
                    repeat (4) @(posedge clk);
                end
            end
            begin
                for (int n = 0; n < 256 * 5 + 20; n++) begin
                    @(negedge clk);
                    if (busy4 && done4) overlap = 1'b1;
                    if (done4) begin
                        idx  = doneSeen[7:0];
                        exp4 = {1'b0, idx[7:4]} + {1'b0, idx[3:0]};
                        if ({cout4, sum4} !== exp4) begin
                            checkOutput($sformatf("exh_%0h_plus_%0h", idx[7:4], idx[3:0]),
                                        32'({cout4, sum4}), 32'(exp4));
                        end else begin
                            testsRun++;
                        end
                        doneSeen++;
                    end
                end
            end
        join
        checkOutput("exh_done_count", 32'(doneSeen), 32'd256);
        checkOutput("exh_busy_done_overlap", 32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
